// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - user-input peripheral address map and key count
package key_pkg;

    localparam int          KEY_NUM        = 8;
    localparam logic [31:0] LED_ADDR       = 32'h00007f20;
    localparam logic [31:0] SWITCH_ADDR    = 32'h00007f2c;
    localparam logic [31:0] KEY_ADDR_LEVEL = 32'h00007f34;
    localparam logic [31:0] KEY_ADDR_EVENT = 32'h00007f38;
    localparam logic [31:0] KEY_ADDR_MASK  = 32'h00007f3c;

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - per-key synchroniser, debounce counter and stable level
module key_debounce_cell #(
    parameter int DEB_CYCLES = 250000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int             CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] count;

    // Polarity is folded in before the synchroniser so that reset (0) means "not pressed".
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            count  <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= raw ^ ACTIVE_LOW;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                level <= sync_b;
                rise  <= sync_b;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_debounce_latch.sv
// rtl/key_debounce_latch.sv - debounced keys with sticky W1C press flags; KEYPAD_IRQ_EN adds mask/irq
module key_debounce_latch
    import key_pkg::*;
#(
    parameter int NUM_KEYS   = KEY_NUM,
    parameter int DEB_CYCLES = 250000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic [31:0]         addr,
    input  logic                we,
    input  logic [31:0]         datain,
    output logic [31:0]         dataout,
    output logic [NUM_KEYS-1:0] user_key,
    output logic                irq
);

    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] flag;
    logic [NUM_KEYS-1:0] clr;
    logic                unused_datain;

    assign unused_datain = ^datain[31:NUM_KEYS];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_cell #(
            .DEB_CYCLES(DEB_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .raw  (key_raw[i]),
            .level(user_key[i]),
            .rise (rise[i])
        );
    end

    assign clr = (we && addr == KEY_ADDR_EVENT) ? datain[NUM_KEYS-1:0] : '0;

    // OR-ing rise in after the clear makes a coincident press win over W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= '0;
        end else begin
            flag <= (flag & ~clr) | rise;
        end
    end

`ifdef KEYPAD_IRQ_EN
    logic [NUM_KEYS-1:0] mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (we && addr == KEY_ADDR_MASK) begin
                mask <= datain[NUM_KEYS-1:0];
            end
            irq <= |(flag & mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        dataout = 32'h0;
        case (addr)
            KEY_ADDR_LEVEL: dataout = 32'(user_key);
            KEY_ADDR_EVENT: dataout = 32'(flag);
`ifdef KEYPAD_IRQ_EN
            KEY_ADDR_MASK:  dataout = 32'(mask);
`endif
            default:        dataout = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_key_debounce_latch.sv
// tb/tb_key_debounce_latch.sv - scoreboard bench for key_debounce_latch (DEB_CYCLES=4)
module tb_key_debounce_latch;

    localparam int          DEB    = 4;
    localparam logic [31:0] A_LVL  = 32'h00007f34;
    localparam logic [31:0] A_EVT  = 32'h00007f38;
    localparam logic [31:0] A_MSK  = 32'h00007f3c;
    localparam logic [31:0] A_NONE = 32'h00007f40;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  key_raw;
    logic [31:0] addr;
    logic        we;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic [7:0]  user_key;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q[$];
    logic [31:0] expv;
    logic [31:0] got;

    key_debounce_latch #(
        .NUM_KEYS  (8),
        .DEB_CYCLES(DEB),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw),
        .addr    (addr),
        .we      (we),
        .datain  (datain),
        .dataout (dataout),
        .user_key(user_key),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = dataout;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        datain = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        datain = 32'h0;
    endtask

    task automatic check(input string name, input logic [31:0] obs);
        expv = exp_q.pop_front();
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, obs, expv);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; key_raw = 8'hFF; addr = 0; we = 0; datain = 0;
        tick(3);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        check("reset_user_key", 32'(user_key));
        check("reset_irq", 32'(irq));
        rd(A_EVT, got); check("reset_event", got);
        rd(A_LVL, got); check("reset_level", got);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_press;
        key_raw[0] = 1'b0;
        for (int t = 1; t <= 2 + DEB; t++) exp_q.push_back(t == 2 + DEB ? 32'h1 : 32'h0);
        for (int t = 1; t <= 2 + DEB; t++) begin
            tick();
            check($sformatf("press_latency_t%0d", t), 32'(user_key));
        end
        tick();
        exp_q.push_back(32'h1);
        rd(A_EVT, got); check("press_event", got);
        key_raw[0] = 1'b1;
        tick(2 + DEB + 2);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        check("release_level", 32'(user_key));
        rd(A_EVT, got); check("release_keeps_flag", got);
        wr(A_EVT, 32'hFF);
        exp_q.push_back(32'h0);
        rd(A_EVT, got); check("clear_all", got);
    endtask

    task automatic test_bounce;
        int pattern[4] = '{3, 1, 3, 8};
        for (int p = 0; p < 4; p++) begin
            key_raw[3] = p[0];
            for (int t = 0; t < pattern[p]; t++) begin
                tick();
                exp_q.push_back(32'h0);
                check("bounce_level", 32'(user_key));
            end
        end
        exp_q.push_back(32'h0);
        rd(A_EVT, got); check("bounce_event", got);
    endtask

    task automatic test_w1c;
        key_raw[0] = 1'b0; key_raw[2] = 1'b0;
        tick(2 + DEB + 2);
        key_raw[0] = 1'b1; key_raw[2] = 1'b1;
        tick(2 + DEB + 2);
        exp_q.push_back(32'h5); exp_q.push_back(32'h4);
        rd(A_EVT, got); check("flags_05", got);
        wr(A_EVT, 32'h1);
        rd(A_EVT, got); check("w1c_bit0", got);
        wr(A_LVL, 32'hFF);
        wr(A_NONE, 32'hFF);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h0);
        rd(A_LVL, got); check("level_write_ignored", got);
        rd(A_EVT, got); check("event_after_level_write", got);
        rd(A_NONE, got); check("unmapped_read", got);
    endtask

    task automatic test_set_wins;
        wr(A_EVT, 32'hFF);
        key_raw[2] = 1'b0;
        tick(2 + DEB);
        exp_q.push_back(32'h4);
        check("set_wins_level", 32'(user_key));
        wr(A_EVT, 32'h4);
        exp_q.push_back(32'h4);
        rd(A_EVT, got); check("set_wins_flag", got);
        key_raw[2] = 1'b1;
        tick(2 + DEB + 2);
    endtask

    task automatic test_reset_mid;
        key_raw[5] = 1'b0;
        tick(4);
        reset = 1'b1;
        tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        check("midreset_user_key", 32'(user_key));
        check("midreset_irq", 32'(irq));
        rd(A_EVT, got); check("midreset_event", got);
        reset = 1'b0;
        for (int t = 1; t <= 2 + DEB; t++) exp_q.push_back(t == 2 + DEB ? 32'h20 : 32'h0);
        for (int t = 1; t <= 2 + DEB; t++) begin
            tick();
            check($sformatf("reaccept_t%0d", t), 32'(user_key));
        end
        tick();
        exp_q.push_back(32'h20);
        rd(A_EVT, got); check("reaccept_flag5", got);
        key_raw[5] = 1'b1;
        tick(2 + DEB + 2);
        wr(A_EVT, 32'hFF);
    endtask

    task automatic test_irq;
`ifdef KEYPAD_IRQ_EN
        wr(A_MSK, 32'h0000_0302);
        exp_q.push_back(32'h2);
        rd(A_MSK, got); check("mask_read", got);
        key_raw[1] = 1'b0;
        tick(2 + DEB + 1);
        exp_q.push_back(32'h2); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        rd(A_EVT, got); check("irq_flag1", got);
        check("irq_lag", 32'(irq));
        tick();
        check("irq_rise", 32'(irq));
        wr(A_EVT, 32'h2);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        check("irq_hold_after_clear", 32'(irq));
        tick();
        check("irq_fall", 32'(irq));
`else
        wr(A_MSK, 32'hFF);
        exp_q.push_back(32'h0);
        rd(A_MSK, got); check("mask_absent", got);
        key_raw[1] = 1'b0;
        for (int t = 0; t < 2 + DEB + 4; t++) begin
            tick();
            exp_q.push_back(32'h0);
            check("irq_tied_low", 32'(irq));
        end
        exp_q.push_back(32'h2);
        rd(A_EVT, got); check("poll_flag1", got);
`endif
        key_raw[1] = 1'b1;
        tick(2 + DEB + 2);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_w1c();
        test_set_wins();
        test_reset_mid();
        test_irq();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
